// File: rtl/dmem_pkg.sv
// Types, op encodings and request-decode helpers shared by the pipelined data memory.
`include "RISCV_defs.svh"

package dmem_pkg;

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    localparam int OPW = `DM_OPSLEN;

    localparam logic [OPW-1:0] OP_LB  = `DM_OP_LB;
    localparam logic [OPW-1:0] OP_LH  = `DM_OP_LH;
    localparam logic [OPW-1:0] OP_LW  = `DM_OP_LW;
    localparam logic [OPW-1:0] OP_LBU = `DM_OP_LBU;
    localparam logic [OPW-1:0] OP_LHU = `DM_OP_LHU;
    localparam logic [OPW-1:0] OP_SB  = `DM_OP_SB;
    localparam logic [OPW-1:0] OP_SH  = `DM_OP_SH;
    localparam logic [OPW-1:0] OP_SW  = `DM_OP_SW;

    // Access size in bytes; store codes share the load codes for B/H/W.
    function automatic logic [2:0] op_size(input logic [OPW-1:0] op);
        case (op)
            OP_LB, OP_LBU: return 3'd1;
            OP_LH, OP_LHU: return 3'd2;
            OP_LW:         return 3'd4;
            default:       return 3'd0;
        endcase
    endfunction

    function automatic logic op_legal(input logic we, input logic [OPW-1:0] op);
        if (we)
            return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus of the data memory; master issues requests, slave answers.
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [OPW-1:0]  req_op;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/RISCV_defs.svh
// Shared RISC-V load/store operation encodings (funct3 values) used by the data memory.
`ifndef RISCV_DEFS_SVH
`define RISCV_DEFS_SVH
`define DM_OPSLEN 3
`define DM_OP_LB  3'b000
`define DM_OP_LH  3'b001
`define DM_OP_LW  3'b010
`define DM_OP_LBU 3'b100
`define DM_OP_LHU 3'b101
`define DM_OP_SB  3'b000
`define DM_OP_SH  3'b001
`define DM_OP_SW  3'b010
`endif

// File: rtl/dmem_byte_lane.sv
// One byte-wide RAM lane with a single write port and a registered read port.
module dmem_byte_lane #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i)
            mem_q[addr_i] <= wdata_i;
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_pipelined.sv
// Pipelined byte-lane data memory: clears itself after reset, then serves aligned
// B/H/W loads and stores with a fixed response latency and fault reporting.
module dmem_pipelined
    import dmem_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH_BYTES = 1024,
    parameter int RD_LAT      = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_if.slave           bus,
    output logic            fault_sticky,
    output logic [XLEN-1:0] fault_addr
);

    localparam int NB     = XLEN / 8;
    localparam int OFFW   = $clog2(NB);
    localparam int NWORDS = DEPTH_BYTES / NB;
    localparam int AW     = $clog2(NWORDS);

    state_e          state_q;
    logic [AW-1:0]   idx_q;
    logic            ready_q;
    logic            fault_sticky_q;
    logic [XLEN-1:0] fault_addr_q;

    logic            accept;
    logic [2:0]      size;
    logic            legal, misalign, oor, fault;
    logic [XLEN:0]   last;
    logic [OFFW-1:0] off;
    logic [AW-1:0]   word;
    logic [NB-1:0]   mask;
    logic [NB-1:0]   lane_we;
    logic [AW-1:0]   lane_addr;
    logic [XLEN-1:0] lane_wdata;

    logic            vld_p1, err_p1, ld_p1;
    logic [OPW-1:0]  op_p1;
    logic [OFFW-1:0] off_p1;
    logic [XLEN-1:0] word_p1, rdata_p1;

    function automatic logic [XLEN-1:0] load_fmt(input logic [OPW-1:0] op,
                                                 input logic [OFFW-1:0] o,
                                                 input logic [XLEN-1:0] w);
        logic [XLEN-1:0] sh, res;
        sh  = w >> {o, 3'b000};
        res = '0;
        case (op)
            OP_LB:   res = {{(XLEN-8){sh[7]}}, sh[7:0]};
            OP_LBU:  res[7:0] = sh[7:0];
            OP_LH:   res = {{(XLEN-16){sh[15]}}, sh[15:0]};
            OP_LHU:  res[15:0] = sh[15:0];
            OP_LW:   res[31:0] = sh[31:0];
            default: res = '0;
        endcase
        return res;
    endfunction

    // Clearing FSM: walks every word once, then accepts requests forever.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (idx_q == AW'(NWORDS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    // p0: decode, fault detection and store lane steering in the acceptance cycle
    assign accept = bus.req_valid & ready_q;

    always_comb begin
        size     = op_size(bus.req_op);
        legal    = op_legal(bus.req_we, bus.req_op);
        misalign = ((size == 3'd2) && bus.req_addr[0]) ||
                   ((size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
        // One extra bit so an address near the top of the space cannot wrap into range.
        last     = {1'b0, bus.req_addr} + (XLEN+1)'(size) - (XLEN+1)'(1);
        oor      = last >= (XLEN+1)'(DEPTH_BYTES);
        fault    = ~legal | misalign | oor;
        off      = bus.req_addr[OFFW-1:0];
        word     = bus.req_addr[OFFW +: AW];
        case (size)
            3'd1:    mask = NB'(1)  << off;
            3'd2:    mask = NB'(3)  << off;
            3'd4:    mask = NB'(15) << off;
            default: mask = '0;
        endcase
        if (state_q == ST_INIT) begin
            lane_we    = '1;
            lane_addr  = idx_q;
            lane_wdata = '0;
        end else begin
            lane_we    = (accept && bus.req_we && !fault) ? mask : '0;
            lane_addr  = word;
            lane_wdata = bus.req_wdata << {off, 3'b000};
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_lane
        dmem_byte_lane #(.DEPTH(NWORDS)) u_lane (
            .clk     (clk),
            .we_i    (lane_we[i]),
            .addr_i  (lane_addr),
            .wdata_i (lane_wdata[8*i +: 8]),
            .rdata_o (word_p1[8*i +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_sticky_q <= 1'b0;
            fault_addr_q   <= '0;
        end else if (accept && fault && !fault_sticky_q) begin
            fault_sticky_q <= 1'b1;
            fault_addr_q   <= bus.req_addr;
        end
    end

    // p1: lane read data arrives; format it alongside the request's metadata
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= accept;
    end

    always_ff @(posedge clk) begin
        err_p1 <= fault;
        ld_p1  <= ~bus.req_we & ~fault;
        op_p1  <= bus.req_op;
        off_p1 <= off;
    end

    assign rdata_p1 = ld_p1 ? load_fmt(op_p1, off_p1, word_p1) : '0;

    // p2..: optional delay line stretching the response to RD_LAT cycles
    if (RD_LAT == 1) begin : g_lat1
        assign bus.resp_valid = vld_p1;
        assign bus.resp_rdata = vld_p1 ? rdata_p1 : '0;
        assign bus.resp_err   = vld_p1 & err_p1;
    end else begin : g_latn
        localparam int ND = RD_LAT - 1;
        logic [ND-1:0]   vld_pn;
        logic [ND-1:0]   err_pn;
        logic [XLEN-1:0] rdata_pn [ND];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_pn <= '0;
            end else begin
                vld_pn[0] <= vld_p1;
                for (int i = 1; i < ND; i++) vld_pn[i] <= vld_pn[i-1];
            end
        end

        always_ff @(posedge clk) begin
            err_pn[0]   <= err_p1;
            rdata_pn[0] <= rdata_p1;
            for (int i = 1; i < ND; i++) begin
                err_pn[i]   <= err_pn[i-1];
                rdata_pn[i] <= rdata_pn[i-1];
            end
        end

        assign bus.resp_valid = vld_pn[ND-1];
        assign bus.resp_rdata = vld_pn[ND-1] ? rdata_pn[ND-1] : '0;
        assign bus.resp_err   = vld_pn[ND-1] & err_pn[ND-1];
    end

    assign bus.req_ready    = ready_q;
    assign fault_sticky     = fault_sticky_q;
    assign fault_addr       = fault_addr_q;

endmodule
